// File: rtl/controle_ula_mult.sv
// ALU control for the multicycle MIPS datapath: registered ALU op decode plus
// an iterative unsigned multiply/divide engine writing the HI/LO registers.
module controle_ula_mult #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        controle,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OP_W-1:0]   saida,
    output logic              busy,
    output logic              done,
    output logic              erro,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; decodes and completes single-cycle ops
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                state;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     opnd;
    logic [CNT_W-1:0]      cnt;

    logic [2:0]            dec_op;
    logic                  dec_err;
    logic                  dec_mul;
    logic                  dec_div;

    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [2*DATA_W:0]     div_sh;
    logic [DATA_W:0]       div_rem;
    logic [DATA_W-1:0]     div_diff;
    logic [2*DATA_W-1:0]   div_next;

    assign busy = (state != IDLE);

    always_comb begin
        dec_op  = 3'b000;
        dec_err = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (controle)
            2'b00: dec_op = 3'b001;
            2'b01: dec_op = 3'b010;
            2'b11: dec_op = 3'b000;
            default: begin
                case (funct)
                    6'h20, 6'h21: dec_op = 3'b001;
                    6'h22, 6'h23: dec_op = 3'b010;
                    6'h24:        dec_op = 3'b011;
                    6'h25:        dec_op = 3'b100;
                    6'h26:        dec_op = 3'b110;
                    6'h2A:        dec_op = 3'b111;
                    6'h19:        dec_mul = 1'b1;
                    6'h1B:        dec_div = 1'b1;
                    default:      dec_err = 1'b1;
                endcase
            end
        endcase
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[DATA_W-1:1]};
        div_sh   = {acc, 1'b0};
        div_rem  = div_sh[2*DATA_W:DATA_W];
        div_diff = div_rem[DATA_W-1:0] - opnd;
        if (div_rem >= {1'b0, opnd})
            div_next = {div_diff, acc[DATA_W-2:0], 1'b1};
        else
            div_next = div_sh[2*DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            saida <= '0;
            done  <= 1'b0;
            erro  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            erro <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        saida <= OP_W'(dec_op);
                        if (dec_mul) begin
                            state <= MUL;
                            opnd  <= a;
                            acc   <= {{DATA_W{1'b0}}, b};
                            cnt   <= CNT_W'(DATA_W);
                        end else if (dec_div) begin
                            if (b == '0) begin
                                done <= 1'b1;
                                erro <= 1'b1;
                            end else begin
                                state <= DIV;
                                opnd  <= b;
                                acc   <= {{DATA_W{1'b0}}, a};
                                cnt   <= CNT_W'(DATA_W);
                            end
                        end else begin
                            done <= 1'b1;
                            erro <= dec_err;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= mul_next[2*DATA_W-1:DATA_W];
                        lo    <= mul_next[DATA_W-1:0];
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        hi    <= div_next[2*DATA_W-1:DATA_W];
                        lo    <= div_next[DATA_W-1:0];
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_ula_mult.sv
// Directed bench for controle_ula_mult: decode sweep, illegal funct, MULTU,
// DIVU, divide by zero, reset mid-operation and back-to-back operations.
module tb_controle_ula_mult;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  controle;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  saida;
    logic        busy;
    logic        done;
    logic        erro;
    logic [31:0] hi;
    logic [31:0] lo;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int n;
    int seen;

    controle_ula_mult #(.DATA_W(32), .OP_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .controle(controle),
        .funct(funct), .a(a), .b(b), .saida(saida), .busy(busy),
        .done(done), .erro(erro), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // start held for one edge; returns at the sample point after acceptance
    task automatic issue(input logic [1:0] ctl, input logic [5:0] fn);
        controle = ctl;
        funct    = fn;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic decode_chk(input string tag, input logic [1:0] ctl,
                              input logic [5:0] fn, input logic [2:0] exp_op);
        issue(ctl, fn);
        chk({tag, "_saida"}, saida, exp_op);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_erro"}, erro, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        controle = 2'b00;
        funct    = 6'h00;
        a        = '0;
        b        = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_saida", saida, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_erro", erro, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        decode_chk("add", 2'b10, 6'h20, 3'b001);
        decode_chk("subu", 2'b10, 6'h23, 3'b010);
        decode_chk("and", 2'b10, 6'h24, 3'b011);
        decode_chk("or", 2'b10, 6'h25, 3'b100);
        decode_chk("xor", 2'b10, 6'h26, 3'b110);
        decode_chk("slt", 2'b10, 6'h2A, 3'b111);
        decode_chk("c00", 2'b00, 6'h2A, 3'b001);
        decode_chk("c01", 2'b01, 6'h2A, 3'b010);
        decode_chk("c11", 2'b11, 6'h24, 3'b000);
        @(negedge clk);
        chk("saida_hold", saida, 3'b000);
        chk("done_drop", done, 1'b0);

        issue(2'b10, 6'h3F);
        chk("ill_saida", saida, 3'b000);
        chk("ill_done", done, 1'b1);
        chk("ill_erro", erro, 1'b1);
        chk("ill_hi", hi, 32'h0);
        chk("ill_lo", lo, 32'h0);
        @(negedge clk);
        chk("ill_done_off", done, 1'b0);
        chk("ill_erro_off", erro, 1'b0);

        a = 32'hFFFF_FFFF;
        b = 32'h0000_0002;
        issue(2'b10, 6'h19);
        chk("mul_busy", busy, 1'b1);
        chk("mul_saida", saida, 3'b000);
        a = '0;
        b = '0;
        controle = 2'b10;
        funct = 6'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        n++;
        chk("mul_latency", n, 33);
        chk("mul_ignored", saida, 3'b000);
        chk("mul_done", done, 1'b1);
        chk("mul_erro", erro, 1'b0);
        chk("mul_hi", hi, 32'h0000_0001);
        chk("mul_lo", lo, 32'hFFFF_FFFE);

        a = 32'd100;
        b = 32'd7;
        issue(2'b10, 6'h1B);
        chk("div_busy", busy, 1'b1);
        wait_idle(n);
        chk("div_latency", n, 33);
        chk("div_done", done, 1'b1);
        chk("div_erro", erro, 1'b0);
        chk("div_lo", lo, 32'd14);
        chk("div_hi", hi, 32'd2);
        @(negedge clk);
        chk("div_done_off", done, 1'b0);

        a = 32'd5;
        b = 32'd0;
        issue(2'b10, 6'h1B);
        chk("dz_busy", busy, 1'b0);
        chk("dz_done", done, 1'b1);
        chk("dz_erro", erro, 1'b1);
        chk("dz_hi", hi, 32'd2);
        chk("dz_lo", lo, 32'd14);

        a = 32'd9;
        b = 32'd9;
        issue(2'b10, 6'h19);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_hi", hi, 32'h0);
        chk("mrst_lo", lo, 32'h0);
        chk("mrst_done", done, 1'b0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("mrst_no_done", seen, 0);

        a = 32'd3;
        b = 32'd4;
        issue(2'b10, 6'h19);
        wait_idle(n);
        chk("mul34_latency", n, 33);
        chk("mul34_lo", lo, 32'd12);
        chk("mul34_hi", hi, 32'd0);

        a = 32'hFFFF_FFFF;
        b = 32'h0000_0010;
        issue(2'b10, 6'h1B);
        wait_idle(n);
        chk("b2b_div_done", done, 1'b1);
        chk("b2b_div_lo", lo, 32'h0FFF_FFFF);
        chk("b2b_div_hi", hi, 32'h0000_000F);
        a = 32'd6;
        b = 32'd7;
        issue(2'b10, 6'h19);
        chk("b2b_mul_busy", busy, 1'b1);
        wait_idle(n);
        chk("b2b_mul_latency", n, 33);
        chk("b2b_mul_done", done, 1'b1);
        chk("b2b_mul_lo", lo, 32'd42);
        chk("b2b_mul_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/controle_ula_mult.md
Name: controle_ula_mult

Overview:
Parametrised ALU-control successor for the multicycle MIPS datapath. It decodes the main-control ALU class and the R-type funct field into a registered ALU operation code. It also owns an iterative unsigned multiply/divide engine with HI/LO result registers and a start/busy/done handshake. It sits between the main control FSM and the ALU/HI-LO datapath. The control FSM stalls on busy.

Parameters:
DATA_W, 32, operand width, and width of HI and LO (>=4).
OP_W, 3, width of the ALU operation code (>=3; codes are zero-extended).
CNT_W, $clog2(DATA_W)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  synchronous, active-low reset.
start  in  1  request strobe; sampled only when busy=0.
controle  in  2  ALU class from main control: 00 add, 01 sub, 10 R-type, 11 pass.
funct  in  6  instruction[5:0]; meaningful only when controle=10.
a  in  DATA_W  operand rs (multiplicand / dividend).
b  in  DATA_W  operand rt (multiplier / divisor).
saida  out  OP_W  registered ALU operation code.
busy  out  1  multiply/divide in progress.
done  out  1  one-cycle completion pulse.
erro  out  1  illegal funct or divide by zero; valid while done=1.
hi  out  DATA_W  HI register.
lo  out  DATA_W  LO register.

Behaviour:
- Reset: reset_n=0 at a rising edge forces the state to IDLE and clears saida, busy, done, erro, hi, lo and all internal registers to 0. This applies in every state, including mid-operation.
- Reset mid-operation abandons the operation. No done pulse follows.
- States: IDLE, MUL, DIV.
  - busy=1 exactly when the state is MUL or DIV.
  - start is accepted only in IDLE. start in MUL or DIV is ignored and not queued.
- Acceptance (IDLE, start=1), decoded at that edge:
  - controle=00 -> saida=001.
  - controle=01 -> saida=010.
  - controle=11 -> saida=000.
  - controle=10 by funct:
    - 0x20, 0x21 -> 001 (add)
    - 0x22, 0x23 -> 010 (sub)
    - 0x24 -> 011 (and)
    - 0x25 -> 100 (or)
    - 0x26 -> 110 (xor)
    - 0x2A -> 111 (slt)
    - 0x19 MULTU -> enter MUL, saida=000
    - 0x1B DIVU -> enter DIV, saida=000
    - any other funct -> saida=000, erro=1
  - Single-cycle codes: done=1 in the following cycle, with erro=0 unless the funct is illegal. hi and lo are unchanged.
- saida holds its value until the next accepted start.
- done and erro are deasserted the cycle after the pulse. erro=0 whenever done=0.
- MUL (shift-add, unsigned):
  - Latch a and b at acceptance.
  - The 2*DATA_W accumulator starts as {0, b}.
  - Each cycle: if acc[0]=1, add a to acc[2*DATA_W-1:DATA_W] with a carry bit; then shift acc right by 1.
  - Exactly DATA_W iterations, counted by CNT_W.
  - On the last iteration edge, {hi, lo} is written with the product, the state returns to IDLE, and done=1 in the next cycle.
  - done is asserted DATA_W+1 cycles after the accepting edge. busy is high for DATA_W cycles.
- DIV (restoring, unsigned):
  - Quotient goes to lo, remainder to hi. Same latency as MUL.
  - Each iteration: shift {rem, quo} left, trial-subtract b, and keep the difference if it is non-negative, setting the quotient bit.
  - Divide by zero (b=0): no iterations, and the state stays IDLE. In the next cycle done=1 and erro=1. hi and lo are unchanged.
- hi and lo change only at MUL/DIV completion or reset.
- A new start may be accepted in the same cycle that done=1, since the state is already IDLE.
- a, b, controle and funct may change freely after acceptance without affecting an operation in progress.

Test Plan:
1. Reset then decode sweep:
   - Hold reset_n=0 for 2 cycles: all outputs 0.
   - controle=10, start pulsed with funct 0x20, 0x23, 0x24, 0x25, 0x26, 0x2A -> saida 001, 010, 011, 100, 110, 111 one cycle later; done pulses; erro=0.
   - controle=00, 01, 11 -> saida 001, 010, 000.
2. Illegal funct: controle=10, funct=0x3F -> saida=000; done=1 and erro=1 for exactly one cycle; hi and lo unchanged.
3. MULTU with a=0xFFFFFFFF, b=0x00000002:
   - busy=1 for 32 cycles.
   - done at cycle 33 with hi=0x00000001, lo=0xFFFFFFFE.
   - A start with funct=0x20 during busy is ignored: saida stays 000.
4. DIVU:
   - a=100, b=7 -> after 33 cycles lo=14, hi=2, erro=0.
   - Then a=5, b=0 -> done one cycle later with erro=1; hi=2 and lo=14 retained.
5. Reset mid-multiply: reset_n=0 at iteration 10 -> next cycle busy=0, hi=lo=0, and no done follows. A subsequent MULTU 3x4 gives lo=12, hi=0.
6. Back-to-back: issue DIVU 0xFFFFFFFF/0x10 and assert start with MULTU 6x7 in the done cycle -> first result lo=0x0FFFFFFF, hi=0xF; second done 33 cycles later with lo=42, hi=0.
